// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART RX controller: one write per data_valid frame,
// first-word fall-through read port, sticky overrun. Optional almost_full via UART_RX_FIFO_AF_EN.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int AF_THRESH  = DEPTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       count,
  output logic                  overrun,
  input  logic                  clr_overrun
`ifdef UART_RX_FIFO_AF_EN
  ,
  output logic                  almost_full
`endif
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_W:0]       wr_ptr_r;
  logic [ADDR_W:0]       rd_ptr_r;
  logic                  dv_q_r;
  logic                  overrun_r;

  logic                  wr_stb_s;
  logic                  rd_fire_s;
  logic                  wr_acc_s;
  logic                  drop_s;
  logic                  full_s;
  logic                  empty_s;
  logic [ADDR_W:0]       count_s;

  // Pointer MSB distinguishes full from empty when the indices coincide.
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                    (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
  assign count_s  = wr_ptr_r - rd_ptr_r;

  assign wr_stb_s  = data_valid & ~dv_q_r;
  assign rd_fire_s = ~empty_s & rd_ready;
  assign wr_acc_s  = wr_stb_s & (~full_s | rd_fire_s);
  assign drop_s    = wr_stb_s & full_s & ~rd_fire_s;

  assign rd_data  = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r[ADDR_W-1:0]];
  assign rd_valid = ~empty_s;
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_s;
  assign overrun  = overrun_r;

`ifdef UART_RX_FIFO_AF_EN
  localparam logic [ADDR_W:0] AF_LVL = AF_THRESH[ADDR_W:0];
  assign almost_full = (count_s >= AF_LVL);
`endif

  // Pointers, frame-edge detector and sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r  <= {(ADDR_W+1){1'b0}};
      rd_ptr_r  <= {(ADDR_W+1){1'b0}};
      dv_q_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      dv_q_r <= data_valid;
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + (ADDR_W+1)'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + (ADDR_W+1)'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      // A new drop wins over a clear requested in the same cycle.
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clr_overrun) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= p_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table for single-frame and fill/drain,
// hand sequences with a queue model for full-with-read, wrap, overrun clear and async reset.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overrun;
  logic       clr_overrun;
`ifdef UART_RX_FIFO_AF_EN
  logic       almost_full;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
`ifdef UART_RX_FIFO_AF_EN
    ,
    .almost_full (almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pd;
    logic       dv;
    logic       rr;
    logic       clr;
    logic [7:0] e_rd;
    logic       e_v;
    logic [3:0] e_cnt;
    logic       e_full;
    logic       e_empty;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[$];

  // Reference model state for the hand-written sequences.
  logic [7:0] m_q[$];
  logic       m_dv;
  logic       m_ovr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [7:0] pd, input logic dv, input logic rr, input logic clr,
                     input logic [7:0] e_rd, input logic e_v, input logic [3:0] e_cnt,
                     input logic e_full, input logic e_empty, input logic e_ovr);
    vec_t v;
    v.pd = pd; v.dv = dv; v.rr = rr; v.clr = clr;
    v.e_rd = e_rd; v.e_v = e_v; v.e_cnt = e_cnt;
    v.e_full = e_full; v.e_empty = e_empty; v.e_ovr = e_ovr;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic [3:0] exp_cnt;
    exp_cnt = 4'(m_q.size());
    chk({tag, " count"}, 32'(count), 32'(exp_cnt));
    chk({tag, " empty"}, 32'(empty), 32'(m_q.size() == 0));
    chk({tag, " full"}, 32'(full), 32'(m_q.size() == 8));
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(m_q.size() != 0));
    chk({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
    if (m_q.size() != 0) chk({tag, " rd_data"}, 32'(rd_data), 32'(m_q[0]));
`ifdef UART_RX_FIFO_AF_EN
    chk({tag, " almost_full"}, 32'(almost_full), 32'(m_q.size() >= 6));
`endif
  endtask

  task automatic cycle(input string tag, input logic [7:0] pd, input logic dv,
                       input logic rr, input logic clr);
    logic fire, stb, acc;
    p_data = pd; data_valid = dv; rd_ready = rr; clr_overrun = clr;
    fire = (m_q.size() != 0) && rr;
    stb  = dv && !m_dv;
    acc  = stb && ((m_q.size() < 8) || fire);
    if (fire) void'(m_q.pop_front());
    if (acc) m_q.push_back(pd);
    if (stb && !acc) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_dv = dv;
    step();
    check_model(tag);
  endtask

  task automatic do_reset();
    data_valid = 1'b0; rd_ready = 1'b0; clr_overrun = 1'b0; p_data = 8'h00;
    rst = 1'b0;
    step();
    rst = 1'b1;
    m_q.delete();
    m_dv = 1'b0;
    m_ovr = 1'b0;
  endtask

  initial begin
    // Vector table: single long frame, then fill/overflow/drain and overrun clear.
    for (int k = 0; k < 10; k++) add(8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int b = 1; b <= 8; b++) begin
      add(8'(b), 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 4'(b), (b == 8), 1'b0, 1'b0);
      add(8'(b), 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 4'(b), (b == 8), 1'b0, 1'b0);
    end
    add(8'h09, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1);
    add(8'h09, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1);
    for (int r = 1; r <= 8; r++)
      add(8'h00, 1'b0, 1'b1, 1'b0, 8'(r + 1), (r < 8), 4'(8 - r), 1'b0, (r == 8), 1'b1);
    add(8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    rst = 1'b0; data_valid = 1'b0; rd_ready = 1'b0; clr_overrun = 1'b0; p_data = 8'h00;
    step();
    step();
    chk("reset count", 32'(count), 32'd0);
    chk("reset empty", 32'(empty), 32'd1);
    chk("reset full", 32'(full), 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      p_data = vecs[i].pd; data_valid = vecs[i].dv;
      rd_ready = vecs[i].rr; clr_overrun = vecs[i].clr;
      step();
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_v));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d overrun", i), 32'(overrun), 32'(vecs[i].e_ovr));
      if (vecs[i].e_v) chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd));
    end

    // Full FIFO: write and read in the same cycle both succeed.
    do_reset();
    for (int b = 1; b <= 8; b++) begin
      cycle("fill3", 8'(b), 1'b1, 1'b0, 1'b0);
      cycle("fill3", 8'(b), 1'b0, 1'b0, 1'b0);
    end
    cycle("wr_rd_full", 8'h09, 1'b1, 1'b1, 1'b0);
    chk("wr_rd_full count", 32'(count), 32'd8);
    chk("wr_rd_full full", 32'(full), 32'd1);
    chk("wr_rd_full overrun", 32'(overrun), 32'd0);
    chk("wr_rd_full head", 32'(rd_data), 32'h02);
    for (int r = 0; r < 9; r++) cycle("drain3", 8'h00, 1'b0, 1'b1, 1'b0);

    // Continuous push/pop across pointer wrap.
    for (int i = 0; i < 40; i++)
      cycle("stream", 8'(8'h80 + i / 2), (i % 2 == 0), (i % 3 != 2), 1'b0);
    for (int i = 0; i < 6; i++) cycle("stream_drain", 8'h00, 1'b0, 1'b1, 1'b0);
    chk("stream empty", 32'(empty), 32'd1);

    // Overrun set beats clear; clear alone then takes effect.
    for (int b = 1; b <= 8; b++) begin
      cycle("fill5", 8'(8'h10 + b), 1'b1, 1'b0, 1'b0);
      cycle("fill5", 8'(8'h10 + b), 1'b0, 1'b0, 1'b0);
    end
    cycle("drop", 8'h55, 1'b1, 1'b0, 1'b0);
    chk("drop overrun", 32'(overrun), 32'd1);
    cycle("drop", 8'h55, 1'b0, 1'b0, 1'b0);
    cycle("drop_clr", 8'h66, 1'b1, 1'b0, 1'b1);
    chk("drop_clr overrun", 32'(overrun), 32'd1);
    cycle("clr_only", 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_only overrun", 32'(overrun), 32'd0);

    // Asynchronous reset with five entries buffered.
    for (int r = 0; r < 3; r++) cycle("to5", 8'h00, 1'b0, 1'b1, 1'b0);
    chk("pre_rst count", 32'(count), 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("async_rst count", 32'(count), 32'd0);
    chk("async_rst empty", 32'(empty), 32'd1);
    chk("async_rst rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_q.delete(); m_dv = 1'b0; m_ovr = 1'b0;
    for (int b = 1; b <= 7; b++) begin
      cycle("af", 8'(8'hC0 + b), 1'b1, 1'b0, 1'b0);
      cycle("af", 8'(8'hC0 + b), 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
